// File: rtl/ram64x16_ctrl.sv
// Clocked request sequencer for the ram64x16 asynchronous SRAM.
// Each request becomes a registered SETUP / STROBE / HOLD strobe sequence.
module ram64x16_ctrl #(
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 16,
  parameter int STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adrs,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_valid,
  output logic              wr_done,
  output logic [ADDR_W-1:0] adrs,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_din_oe,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              _ce,
  output logic              _we,
  output logic              _oe
);

  if (STROBE_CYC < 1) begin : g_strobe_cyc_check
    $error("STROBE_CYC must be at least 1");
  end

  localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adrs_q, adrs_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                ce_n_q, ce_n_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                din_oe_q, din_oe_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_done_q, wr_done_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    adrs_d  = adrs_q;
    din_d   = din_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid && ready_q) begin
          state_d = SETUP;
          we_d    = req_we;
          adrs_d  = req_adrs;
          din_d   = req_wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = CNT_W'(STROBE_CYC - 1);
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!we_q) rdata_d = ram_dout;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Every output is decoded from the next state so it leaves a flop cleanly.
    ce_n_d     = (state_d == IDLE);
    we_n_d     = !((state_d == STROBE) && we_d);
    oe_n_d     = !((state_d == STROBE) && !we_d);
    din_oe_d   = (state_d != IDLE) && we_d;
    rd_valid_d = (state_d == HOLD) && !we_d;
    wr_done_d  = (state_d == HOLD) && we_d;
    ready_d    = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      adrs_q     <= '0;
      din_q      <= '0;
      rdata_q    <= '0;
      ce_n_q     <= 1'b1;
      we_n_q     <= 1'b1;
      oe_n_q     <= 1'b1;
      din_oe_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      wr_done_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      adrs_q     <= adrs_d;
      din_q      <= din_d;
      rdata_q    <= rdata_d;
      ce_n_q     <= ce_n_d;
      we_n_q     <= we_n_d;
      oe_n_q     <= oe_n_d;
      din_oe_q   <= din_oe_d;
      rd_valid_q <= rd_valid_d;
      wr_done_q  <= wr_done_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready  = ready_q;
  assign rdata      = rdata_q;
  assign rd_valid   = rd_valid_q;
  assign wr_done    = wr_done_q;
  assign adrs       = adrs_q;
  assign ram_din    = din_q;
  assign ram_din_oe = din_oe_q;
  assign _ce        = ce_n_q;
  assign _we        = we_n_q;
  assign _oe        = oe_n_q;

endmodule

// File: tb/tb_ram64x16_ctrl.sv
// Bench for ram64x16_ctrl: scoreboarded transactions against an SRAM model,
// plus directed strobe-timing checks for STROBE_CYC=2 and STROBE_CYC=1 builds.
module tb_ram64x16_ctrl;
  localparam int SC = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A (STROBE_CYC=2)
  logic        rst, req_valid, req_ready, req_we, rd_valid, wr_done, ram_din_oe;
  logic        ce_n, we_n, oe_n;
  logic [5:0]  req_adrs, adrs;
  logic [15:0] req_wdata, rdata, ram_din, ram_dout;

  ram64x16_ctrl #(.ADDR_W(6), .DATA_W(16), .STROBE_CYC(SC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_adrs(req_adrs), .req_wdata(req_wdata),
    .rdata(rdata), .rd_valid(rd_valid), .wr_done(wr_done), .adrs(adrs),
    .ram_din(ram_din), .ram_din_oe(ram_din_oe), .ram_dout(ram_dout),
    ._ce(ce_n), ._we(we_n), ._oe(oe_n)
  );

  logic [15:0] mem_a [64];
  always @(posedge clk) if (!ce_n && !we_n) mem_a[adrs] <= ram_din_oe ? ram_din : 16'hBAD0;
  assign ram_dout = (!ce_n && !oe_n) ? mem_a[adrs] : 16'hDEAD;

  // DUT B (STROBE_CYC=1)
  logic        rst_b, req_valid_b, req_ready_b, req_we_b, rd_valid_b, wr_done_b, ram_din_oe_b;
  logic        ce_n_b, we_n_b, oe_n_b;
  logic [5:0]  req_adrs_b, adrs_b;
  logic [15:0] req_wdata_b, rdata_b, ram_din_b, ram_dout_b;

  ram64x16_ctrl #(.ADDR_W(6), .DATA_W(16), .STROBE_CYC(1)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .req_we(req_we_b), .req_adrs(req_adrs_b), .req_wdata(req_wdata_b),
    .rdata(rdata_b), .rd_valid(rd_valid_b), .wr_done(wr_done_b), .adrs(adrs_b),
    .ram_din(ram_din_b), .ram_din_oe(ram_din_oe_b), .ram_dout(ram_dout_b),
    ._ce(ce_n_b), ._we(we_n_b), ._oe(oe_n_b)
  );

  logic [15:0] mem_b [64];
  always @(posedge clk) if (!ce_n_b && !we_n_b) mem_b[adrs_b] <= ram_din_oe_b ? ram_din_b : 16'hBAD0;
  assign ram_dout_b = (!ce_n_b && !oe_n_b) ? mem_b[adrs_b] : 16'hDEAD;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic        we;
    logic [5:0]  a;
    logic [15:0] d;
    logic        dc;
    int          acc;
  } exp_t;

  exp_t        sb [$];
  logic [15:0] shadow [64];
  logic        svld [64] = '{default: 1'b0};

  logic        ce_prev = 1'b1;
  logic [5:0]  adrs_prev = '0;
  logic [15:0] din_prev = '0;
  logic [15:0] last_rd = '0;

  // Monitor for DUT A: scoreboard, latency and strobe invariants.
  always begin : mon
    exp_t e;
    @(negedge clk);
    #1;
    if (rst) begin
      foreach (sb[i]) if (sb[i].we) svld[sb[i].a] = 1'b0;
      sb.delete();
      last_rd = '0;
    end else begin
      if (rd_valid || wr_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, rd_valid, wr_done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("done_kind", {30'd0, rd_valid, wr_done}, e.we ? 32'd1 : 32'd2);
          chk("latency", cyc - e.acc, 2 + SC);
          if (rd_valid && !e.dc) chk($sformatf("rdata_a%0h", e.a), rdata, e.d);
          if (wr_done) chk("rdata_hold", rdata, last_rd);
          if (rd_valid) last_rd = rdata;
        end
      end
      if (req_valid && req_ready) begin
        e.we  = req_we;
        e.a   = req_adrs;
        e.acc = cyc;
        if (req_we) begin
          shadow[req_adrs] = req_wdata;
          svld[req_adrs]   = 1'b1;
          e.d  = req_wdata;
          e.dc = 1'b0;
        end else begin
          e.d  = shadow[req_adrs];
          e.dc = !svld[req_adrs];
        end
        sb.push_back(e);
      end
    end
    if (!we_n || !oe_n) begin
      chk("we_oe_excl", !we_n && !oe_n, 0);
      chk("strobe_needs_ce", ce_n, 0);
    end
    if (!ce_n && !ce_prev) begin
      chk("adrs_stable", adrs, adrs_prev);
      chk("din_stable", ram_din, din_prev);
    end
    ce_prev   = ce_n;
    adrs_prev = adrs;
    din_prev  = ram_din;
  end

  task automatic do_req(input logic we, input logic [5:0] a, input logic [15:0] d);
    int t = 0;
    req_we = we; req_adrs = a; req_wdata = d; req_valid = 1'b1;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_pending", sb.size(), 0);
    @(negedge clk);
  endtask

  logic        b_we [3];
  logic [5:0]  b_a [3];
  logic [15:0] b_d [3];
  int          acc [3];
  logic        ce_hist [16];
  int          n_acc, oe_cnt, wt;
  logic        just;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_adrs_b = '0; req_wdata_b = '0;
    repeat (2) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_adrs  = 6'($urandom);
      req_wdata = 16'($urandom);
      @(posedge clk);
    end
    @(negedge clk);
    chk("rst_ce", ce_n, 1);
    chk("rst_we", we_n, 1);
    chk("rst_oe", oe_n, 1);
    chk("rst_din_oe", ram_din_oe, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_done", wr_done, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_adrs", adrs, 0);
    chk("rst_rdata", rdata, 0);
    rst = 1'b0; rst_b = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    do_req(1'b1, 6'h00, 16'hFFFF);
    do_req(1'b1, 6'h10, 16'hEEEE);
    do_req(1'b1, 6'h20, 16'hDDDD);
    do_req(1'b1, 6'h30, 16'hCCCC);
    do_req(1'b0, 6'h00, 16'h0000);
    do_req(1'b0, 6'h10, 16'h0000);
    do_req(1'b0, 6'h20, 16'h0000);
    do_req(1'b0, 6'h30, 16'h0000);
    drain();

    // Write timing, accept at cycle 0
    chk("wt_ready_c0", req_ready, 1);
    req_we = 1'b1; req_adrs = 6'h2A; req_wdata = 16'h5A5A; req_valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk($sformatf("wt_ce_c%0d", k), ce_n, (k >= 1 && k <= 4) ? 0 : 1);
      chk($sformatf("wt_we_c%0d", k), we_n, (k == 2 || k == 3) ? 0 : 1);
      chk($sformatf("wt_oe_c%0d", k), oe_n, 1);
      chk($sformatf("wt_dinoe_c%0d", k), ram_din_oe, (k >= 1 && k <= 4) ? 1 : 0);
      chk($sformatf("wt_wr_done_c%0d", k), wr_done, (k == 4) ? 1 : 0);
      chk($sformatf("wt_ready_c%0d", k), req_ready, (k == 5) ? 1 : 0);
    end
    drain();

    // Back-to-back with req_valid held high
    b_we[0] = 1'b1; b_a[0] = 6'h05; b_d[0] = 16'h1357;
    b_we[1] = 1'b0; b_a[1] = 6'h05; b_d[1] = 16'h0000;
    b_we[2] = 1'b0; b_a[2] = 6'h20; b_d[2] = 16'h0000;
    n_acc = 0; just = 1'b0;
    req_we = b_we[0]; req_adrs = b_a[0]; req_wdata = b_d[0]; req_valid = 1'b1;
    for (int t = 0; t < 60 && n_acc < 3; t++) begin
      if (n_acc > 0 && cyc - acc[0] < 16) ce_hist[cyc - acc[0]] = ce_n;
      if (req_ready) begin
        acc[n_acc] = cyc;
        n_acc++;
        just = 1'b1;
      end
      @(negedge clk);
      if (just) begin
        just = 1'b0;
        if (n_acc < 3) begin
          req_we = b_we[n_acc]; req_adrs = b_a[n_acc]; req_wdata = b_d[n_acc];
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    chk("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      chk("b2b_acc1", acc[1] - acc[0], 5);
      chk("b2b_acc2", acc[2] - acc[0], 10);
      for (int k = 1; k <= 10; k++)
        chk($sformatf("b2b_ce_c%0d", k), ce_hist[k], (k == 5 || k == 10) ? 1 : 0);
    end
    drain();

    // Reset during the first STROBE cycle of a write
    req_we = 1'b1; req_adrs = 6'h3F; req_wdata = 16'h1234; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("mid_we_low", we_n, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ce", ce_n, 1);
    chk("mid_we", we_n, 1);
    chk("mid_oe", oe_n, 1);
    chk("mid_din_oe", ram_din_oe, 0);
    chk("mid_wr_done", wr_done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_after", req_ready, 1);
    do_req(1'b0, 6'h3F, 16'h0000);
    drain();
    do_req(1'b1, 6'h3F, 16'h1234);
    do_req(1'b0, 6'h3F, 16'h0000);
    drain();

    // STROBE_CYC=1 build
    wt = 0;
    while (!req_ready_b && wt < 20) begin @(negedge clk); wt++; end
    req_we_b = 1'b1; req_adrs_b = 6'h10; req_wdata_b = 16'hABCD; req_valid_b = 1'b1;
    @(negedge clk);
    req_valid_b = 1'b0;
    wt = 0;
    while (!wr_done_b && wt < 20) begin @(negedge clk); wt++; end
    chk("b_wr_done", wr_done_b, 1);
    @(negedge clk);
    chk("b_ready", req_ready_b, 1);
    req_we_b = 1'b0; req_adrs_b = 6'h10; req_valid_b = 1'b1;
    oe_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      req_valid_b = 1'b0;
      if (!oe_n_b) oe_cnt++;
      chk($sformatf("b_rd_valid_c%0d", k), rd_valid_b, (k == 3) ? 1 : 0);
      if (k == 3) chk("b_rdata", rdata_b, 16'hABCD);
    end
    chk("b_oe_cycles", oe_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
